mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store stage downstream of the instruction decoder; consumes MemRead/MemWrite (ctrl[4:3]), size, and the load sign flag (opcode[2]).
- Converts one load/store (lb/lbu/lh/lhu/lw/sb/sh/sw) into a single word-aligned bus transaction with byte enables, using a req/ack handshake.
- Returns an aligned, sign- or zero-extended load result to writeback, with a one-cycle done pulse.
- Little-endian byte lanes.

Parameters:
- ADDR_W, 32, byte-address width of addr and bus_addr.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe from pipeline; sampled only in IDLE
- mem_read  in  1  load (decoder ctrl[4])
- mem_write  in  1  store (decoder ctrl[3])
- size  in  2  00 byte, 01 half, 11 word; 10 treated as word
- unsigned_ld  in  1  1 = zero-extend load (lbu/lhu), 0 = sign-extend
- addr  in  ADDR_W  effective byte address from ALU
- wdata  in  32  store data (rt), right-justified
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result, valid when done=1 and held until next done
- misaligned  out  1  one-cycle error pulse (MISALIGN_TRAP_EN only; tied 0 otherwise)
- bus_req  out  1  memory request, held until bus_ack
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word address, with addr[1:0] forced to 00
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  memory accepts or returns data this cycle
- bus_rdata  in  32  read word, valid when bus_ack=1

Behaviour:
- Reset values: state IDLE; busy, done, misaligned, bus_req, bus_we = 0; bus_addr, bus_be, bus_wdata, rdata = 0.
- FSM states: IDLE, REQ, DONE.
- IDLE: on start & (mem_read|mem_write), latch all inputs, go to REQ. The bus outputs are registered, so bus_req rises in the cycle after start. A start with neither read nor write is ignored.
- Read/write priority: if mem_read and mem_write are both 1, perform a store; the read is ignored.
- Byte enables:
  - byte: be = 1 << addr[1:0].
  - half: be = addr[1] ? 1100 : 0011.
  - word: be = 1111.
- Store data: byte is replicated into all four lanes; half is replicated into both halves; word is passed through.
- REQ: bus_req and all bus outputs are held stable until bus_ack=1. On ack, go to DONE.
- Load extraction on ack:
  - Select the lane given by the latched addr[1:0] (byte) or addr[1] (half).
  - Extend to 32 bits per unsigned_ld; word loads are passed through.
  - Register the result into rdata.
- DONE: done=1 and busy=0 for one cycle, then return to IDLE. A start presented during DONE is ignored; the pipeline issues start only while busy=0 and done=0.
- busy is 1 in REQ.
- Latency: start at cycle 0, bus_req at cycle 1. With zero-wait memory (ack at cycle 1), done is at cycle 2. In general, ack at cycle n gives done at cycle n+1.
- bus_ack is ignored outside REQ.
- start while busy is ignored; no queuing.
- Reset mid-REQ: bus_req drops in the next cycle, and the transaction is abandoned with no done pulse.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misalignment means half with addr[0]=1, or word with addr[1:0]≠00.
  - A misaligned start issues no bus request. The FSM goes IDLE→DONE; misaligned=1 and done=1 in the same cycle (cycle 1); rdata is unchanged.
- Undefined:
  - Offending low address bits are ignored: half uses addr[1], word uses lane 0.
  - misaligned is tied to 0.

Test Plan:
- lw: addr=0x104, bus_rdata=0xDEADBEEF, ack at cycle 1 -> bus_addr=0x104, be=1111, we=0; done at cycle 2; rdata=0xDEADBEEF.
- lb vs lbu: addr=0x203, bus_rdata=0x80112233 -> be=1000; lb gives rdata=0xFFFFFF80; lbu gives rdata=0x00000080.
- sh: addr=0x302, wdata=0x0000ABCD, ack delayed 3 cycles -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, all held stable while waiting; one done pulse, 1 cycle after ack.
- sb with mem_read=mem_write=1: addr=0x1, wdata=0x5A -> write performed, be=0010, bus_wdata=0x5A5A5A5A.
- Reset asserted mid-REQ, then start ignored while busy -> bus_req=0 after reset; no done; next start proceeds normally.
- MISALIGN_TRAP_EN, lw addr=0x102 -> no bus_req; misaligned=1 and done=1 at cycle 1; without the macro -> bus_addr=0x100, be=1111.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit: one load/store becomes a single word-aligned bus transaction with byte enables.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of issuing a bus request.
module mem_access_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        size,
   input  logic              unsigned_ld,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              misaligned,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              w_accept;
   logic              w_misaligned;
   logic              r_unsigned;
   logic [1:0]        r_size;
   logic [1:0]        r_lane;
   logic              r_bus_we;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [3:0]        r_bus_be;
   logic [31:0]       r_bus_wdata;
   logic [31:0]       r_rdata;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [7:0]        w_ld_byte;
   logic [15:0]       w_ld_half;
   logic [31:0]       w_ld_data;

`ifdef MISALIGN_TRAP_EN
   logic r_misaligned;
   assign w_misaligned = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
   assign misaligned   = (r_state == DONE) && r_misaligned;

   always_ff @(posedge clk) begin
      if (reset)
         r_misaligned <= 1'b0;
      else if (w_accept)
         r_misaligned <= w_misaligned;
   end
`else
   assign w_misaligned = 1'b0;
   assign misaligned   = 1'b0;
`endif

   assign w_accept = (r_state == IDLE) && start && (mem_read || mem_write);

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (w_accept) w_state_next = w_misaligned ? DONE : REQ;
         REQ:  if (bus_ack)  w_state_next = DONE;
         DONE: w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = wdata;
      case (size)
         2'b00: begin
            w_be    = 4'b0001 << addr[1:0];
            w_wdata = {4{wdata[7:0]}};
         end
         2'b01: begin
            w_be    = addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane selection uses the address latched at start, not the live addr input
   always_comb begin
      w_ld_byte = bus_rdata[7:0];
      case (r_lane)
         2'b01:   w_ld_byte = bus_rdata[15:8];
         2'b10:   w_ld_byte = bus_rdata[23:16];
         2'b11:   w_ld_byte = bus_rdata[31:24];
         default: w_ld_byte = bus_rdata[7:0];
      endcase
      w_ld_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      w_ld_data = bus_rdata;
      case (r_size)
         2'b00:   w_ld_data = r_unsigned ? {24'b0, w_ld_byte} : {{24{w_ld_byte[7]}}, w_ld_byte};
         2'b01:   w_ld_data = r_unsigned ? {16'b0, w_ld_half} : {{16{w_ld_half[15]}}, w_ld_half};
         default: w_ld_data = bus_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_unsigned  <= 1'b0;
         r_size      <= 2'b00;
         r_lane      <= 2'b00;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_be    <= 4'b0000;
         r_bus_wdata <= 32'h0;
         r_rdata     <= 32'h0;
      end else begin
         if (w_accept && !w_misaligned) begin
            r_unsigned  <= unsigned_ld;
            r_size      <= size;
            r_lane      <= addr[1:0];
            r_bus_we    <= mem_write;
            r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
         end
         if ((r_state == REQ) && bus_ack && !r_bus_we)
            r_rdata <= w_ld_data;
      end
   end

   assign busy      = (r_state == REQ);
   assign bus_req   = (r_state == REQ);
   assign done      = (r_state == DONE);
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_be    = r_bus_be;
   assign bus_wdata = r_bus_wdata;
   assign rdata     = r_rdata;

endmodule
